// File: rtl/regfile_param.sv
// Parametrised register file with write-through read ports, a per-register
// pending scoreboard and a zeroing sweep sequencer that runs after reset or on clear.
module regfile_param #(
    parameter int DATA_W   = 16,
    parameter int ADDR_W   = 4,
    parameter int ZERO_REG = 0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              write,
    input  logic [ADDR_W-1:0] wrAddr,
    input  logic [DATA_W-1:0] wrData,
    input  logic [ADDR_W-1:0] rdAddrA,
    output logic [DATA_W-1:0] rdDataA,
    input  logic [ADDR_W-1:0] rdAddrB,
    output logic [DATA_W-1:0] rdDataB,
    input  logic              lock,
    input  logic [ADDR_W-1:0] lockAddr,
    output logic              pendA,
    output logic              pendB,
    input  logic              clear,
    output logic              busy
);

    // state | meaning
    // IDLE  | array usable; write, lock and clear accepted
    // SWEEP | writing 0 to r_mem[r_ptr] each edge; ports read 0
    typedef enum logic {
        IDLE  = 1'b0,
        SWEEP = 1'b1
    } state_t;

    localparam int DEPTH = 2 ** ADDR_W;

    state_t            r_state;
    logic [ADDR_W-1:0] r_ptr;
    logic              r_busy;
    logic [DEPTH-1:0]  r_pend;
    logic [DATA_W-1:0] r_mem [DEPTH];

    logic w_wr_ok;
    logic w_lock_ok;

    // Register 0 is hardwired when ZERO_REG is set: writes and locks to it vanish.
    assign w_wr_ok   = write && !((ZERO_REG != 0) && (wrAddr == '0));
    assign w_lock_ok = lock  && !((ZERO_REG != 0) && (lockAddr == '0));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= SWEEP;
            r_ptr   <= '0;
            r_busy  <= 1'b1;
            r_pend  <= '0;
        end else begin
            case (r_state)
                SWEEP: begin
                    r_ptr <= r_ptr + ADDR_W'(1);
                    if (r_ptr == ADDR_W'(DEPTH - 1)) begin
                        r_state <= IDLE;
                        r_busy  <= 1'b0;
                    end
                end
                default: begin
                    if (clear) begin
                        r_state <= SWEEP;
                        r_ptr   <= '0;
                        r_busy  <= 1'b1;
                        r_pend  <= '0;
                    end else begin
                        // Lock is applied after the write so it wins on a shared address.
                        if (w_wr_ok)
                            r_pend[wrAddr] <= 1'b0;
                        if (w_lock_ok)
                            r_pend[lockAddr] <= 1'b1;
                    end
                end
            endcase
        end
    end

    // Array data has no reset; the sweep is what zeroes it.
    always_ff @(posedge clk) begin
        if (r_state == SWEEP)
            r_mem[r_ptr] <= '0;
        else if (w_wr_ok)
            r_mem[wrAddr] <= wrData;
    end

    always_comb begin
        rdDataA = '0;
        if (!r_busy && !((ZERO_REG != 0) && (rdAddrA == '0))) begin
            if (write && (wrAddr == rdAddrA))
                rdDataA = wrData;
            else
                rdDataA = r_mem[rdAddrA];
        end
    end

    always_comb begin
        rdDataB = '0;
        if (!r_busy && !((ZERO_REG != 0) && (rdAddrB == '0))) begin
            if (write && (wrAddr == rdAddrB))
                rdDataB = wrData;
            else
                rdDataB = r_mem[rdAddrB];
        end
    end

    assign pendA = !r_busy && r_pend[rdAddrA];
    assign pendB = !r_busy && r_pend[rdAddrB];
    assign busy  = r_busy;

endmodule

// File: tb/tb_regfile_param.sv
// Directed bench for regfile_param: one instance with ZERO_REG=0 and one with
// ZERO_REG=1, sharing all inputs.
module tb_regfile_param;

    logic        clk = 1'b0;
    logic        reset;
    logic        write;
    logic [3:0]  wrAddr;
    logic [15:0] wrData;
    logic [3:0]  rdAddrA;
    logic [3:0]  rdAddrB;
    logic        lock;
    logic [3:0]  lockAddr;
    logic        clear;

    logic [15:0] rdDataA,  rdDataB,  zrdDataA, zrdDataB;
    logic        pendA, pendB, busy, zpendA, zpendB, zbusy;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    regfile_param #(.DATA_W(16), .ADDR_W(4), .ZERO_REG(0)) dut (
        .clk(clk), .reset(reset), .write(write), .wrAddr(wrAddr), .wrData(wrData),
        .rdAddrA(rdAddrA), .rdDataA(rdDataA), .rdAddrB(rdAddrB), .rdDataB(rdDataB),
        .lock(lock), .lockAddr(lockAddr), .pendA(pendA), .pendB(pendB),
        .clear(clear), .busy(busy)
    );

    regfile_param #(.DATA_W(16), .ADDR_W(4), .ZERO_REG(1)) dut_z (
        .clk(clk), .reset(reset), .write(write), .wrAddr(wrAddr), .wrData(wrData),
        .rdAddrA(rdAddrA), .rdDataA(zrdDataA), .rdAddrB(rdAddrB), .rdDataB(zrdDataB),
        .lock(lock), .lockAddr(lockAddr), .pendA(zpendA), .pendB(zpendB),
        .clear(clear), .busy(zbusy)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs;
        write = 1'b0; wrAddr = '0; wrData = '0;
        lock = 1'b0; lockAddr = '0; clear = 1'b0;
    endtask

    // Count edges until busy drops while hammering write/lock/clear, which must be ignored.
    task automatic wait_sweep(input string tag);
        int cnt;
        cnt = 0;
        while (busy && cnt < 40) begin
            write = 1'b1; wrAddr = 4'(cnt); wrData = 16'hFFFF;
            lock = 1'b1; lockAddr = 4'(cnt); clear = (cnt == 5);
            rdAddrA = 4'(cnt); rdAddrB = 4'(cnt + 1);
            if (cnt == 3) begin
                #1;
                check({tag, " rdA in sweep"}, rdDataA, 16'h0);
                check({tag, " pendA in sweep"}, pendA, 1'b0);
            end
            tick();
            cnt++;
        end
        idle_inputs();
        check({tag, " busy cycles"}, cnt, 16);
        check({tag, " zbusy"}, zbusy, 1'b0);
    endtask

    task automatic check_all_zero(input string tag);
        for (int i = 0; i < 16; i++) begin
            rdAddrA = 4'(i); rdAddrB = 4'(15 - i);
            #1;
            check({tag, " rdA"}, rdDataA, 16'h0);
            check({tag, " rdB"}, rdDataB, 16'h0);
            check({tag, " pendA"}, pendA, 1'b0);
            check({tag, " pendB"}, pendB, 1'b0);
            check({tag, " z rdA"}, zrdDataA, 16'h0);
            check({tag, " z pendA"}, zpendA, 1'b0);
        end
    endtask

    initial begin
        idle_inputs();
        rdAddrA = 4'd5; rdAddrB = 4'd9;
        reset = 1'b1;
        #3;
        check("rst busy", busy, 1'b1);
        check("rst rdA", rdDataA, 16'h0);
        check("rst rdB", rdDataB, 16'h0);
        check("rst pendA", pendA, 1'b0);
        check("rst pendB", pendB, 1'b0);
        tick(); tick();
        @(negedge clk);
        reset = 1'b0;
        wait_sweep("init");
        check_all_zero("init");

        // Write with same-cycle bypass, then from the array
        write = 1'b1; wrAddr = 4'd5; wrData = 16'hBEEF; rdAddrA = 4'd5; rdAddrB = 4'd2;
        #1;
        check("bypass rdA", rdDataA, 16'hBEEF);
        check("bypass rdB other", rdDataB, 16'h0);
        tick();
        write = 1'b0; rdAddrB = 4'd5;
        #1;
        check("array rdA", rdDataA, 16'hBEEF);
        check("array rdB", rdDataB, 16'hBEEF);

        // Lock scoreboard
        lock = 1'b1; lockAddr = 4'd3; rdAddrA = 4'd3;
        #1;
        check("lock no bypass", pendA, 1'b0);
        tick();
        lock = 1'b0;
        #1;
        check("lock pendA", pendA, 1'b1);
        write = 1'b1; wrAddr = 4'd3; wrData = 16'h1234;
        #1;
        check("unlock no bypass", pendA, 1'b1);
        tick();
        write = 1'b0;
        #1;
        check("unlock pendA", pendA, 1'b0);
        check("unlock data", rdDataA, 16'h1234);
        lock = 1'b1; lockAddr = 4'd7; write = 1'b1; wrAddr = 4'd7; wrData = 16'h00AA;
        tick();
        idle_inputs();
        rdAddrB = 4'd7;
        #1;
        check("lock+wr pendB", pendB, 1'b1);
        check("lock+wr rdB", rdDataB, 16'h00AA);

        // Zero register behaviour
        write = 1'b1; wrAddr = 4'd1; wrData = 16'h5555;
        tick();
        wrAddr = 4'd0; wrData = 16'hFFFF; rdAddrA = 4'd0;
        #1;
        check("z bypass r0", zrdDataA, 16'h0);
        check("nz bypass r0", rdDataA, 16'hFFFF);
        tick();
        write = 1'b0; lock = 1'b1; lockAddr = 4'd0;
        #1;
        check("z r0 read", zrdDataA, 16'h0);
        check("nz r0 read", rdDataA, 16'hFFFF);
        tick();
        lock = 1'b0; rdAddrB = 4'd1;
        #1;
        check("z r0 pend", zpendA, 1'b0);
        check("nz r0 pend", pendA, 1'b1);
        check("z r1 data", zrdDataB, 16'h5555);

        // Fill, then clear
        for (int i = 0; i < 16; i++) begin
            write = 1'b1; wrAddr = 4'(i); wrData = 16'h1000 + 16'(i);
            tick();
        end
        write = 1'b0; lock = 1'b1; lockAddr = 4'd4;
        tick();
        lock = 1'b0; rdAddrA = 4'd9; rdAddrB = 4'd4;
        #1;
        check("fill r9", rdDataA, 16'h1009);
        check("fill r4 pend", pendB, 1'b1);
        check("fill z r9", zrdDataA, 16'h1009);
        clear = 1'b1;
        tick();
        clear = 1'b0;
        #1;
        check("clear busy", busy, 1'b1);
        check("clear pend", pendB, 1'b0);
        wait_sweep("clear");
        check_all_zero("clear");

        // Async reset while idle with pending state
        lock = 1'b1; lockAddr = 4'd6; write = 1'b1; wrAddr = 4'd6; wrData = 16'h0666;
        tick();
        idle_inputs();
        rdAddrA = 4'd6;
        #1;
        check("pre-rst pend", pendA, 1'b1);
        check("pre-rst data", rdDataA, 16'h0666);
        reset = 1'b1;
        #1;
        check("async rst busy", busy, 1'b1);
        check("async rst pend", pendA, 1'b0);
        check("async rst rdA", rdDataA, 16'h0);
        @(negedge clk);
        reset = 1'b0;
        wait_sweep("rst idle");
        rdAddrA = 4'd6;
        #1;
        check("rst idle r6", rdDataA, 16'h0);
        check("rst idle r6 pend", pendA, 1'b0);

        // Reset at sweep cycle 8 restarts a full sweep
        write = 1'b1; wrAddr = 4'd12; wrData = 16'hC0DE;
        tick();
        write = 1'b0;
        clear = 1'b1;
        tick();
        clear = 1'b0;
        repeat (8) tick();
        reset = 1'b1;
        #1;
        check("mid rst busy", busy, 1'b1);
        check("mid rst rdA", rdDataA, 16'h0);
        check("mid rst pendA", pendA, 1'b0);
        @(negedge clk);
        reset = 1'b0;
        wait_sweep("mid rst");
        check_all_zero("mid rst");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
